// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: issue-stage state codes,
// default operand width and the control FSM state codes for bench monitors.
package mul_pkg;

    localparam int DATA_W = 8;

    // Issue stage FSM
    typedef enum logic [1:0] {
        I_IDLE = 2'b00,
        I_REQ  = 2'b01,
        I_RUN  = 2'b10
    } issue_state_e;

    // Multiplier control FSM states (locked = not IDLE/FINISH, done_flag = FINISH)
    typedef enum logic [2:0] {
        C_IDLE   = 3'd0,
        C_LOAD   = 3'd1,
        C_CHECK  = 3'd2,
        C_ADD    = 3'd3,
        C_SHIFT  = 3'd4,
        C_FINISH = 3'd5
    } ctl_state_e;

endpackage

// File: rtl/mul_operand_fifo.sv
// Operand-pair FIFO with wrap-bit pointers; head entry read combinationally.
module mul_operand_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b
);

    logic [DATA_W-1:0] r_mem_a [DEPTH];
    logic [DATA_W-1:0] r_mem_b [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    // No bypass: a full FIFO refuses pushes even when a pop lands on the same edge
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_a     = r_mem_a[r_rd_ptr[ADDR_W-1:0]];
    assign o_b     = r_mem_b[r_rd_ptr[ADDR_W-1:0]];

    // Storage: written only at wr_ptr, so the head entry is never disturbed by a push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr[ADDR_W-1:0]] <= i_a;
            r_mem_b[r_wr_ptr[ADDR_W-1:0]] <= i_b;
        end
    end

    // Pointer update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mul_issue.sv
// Operand issue stage: buffers operand pairs and hands them one at a time to the
// multiplier control FSM with a start/locked/done_flag handshake.
module mul_issue
    import mul_pkg::*;
#(
    parameter int DATA_W      = mul_pkg::DATA_W,
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 2,
    parameter int REQ_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              start,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              locked,
    input  logic              done_flag,
    output logic [ADDR_W:0]   level,
    output logic              busy,
    output logic              stall,
    output logic              spurious
);

    localparam int TMR_W = $clog2(REQ_TIMEOUT + 1);

    issue_state_e     r_state, w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic             r_spurious;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;

    mul_operand_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_a     (in_a),
        .i_b     (in_b),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level),
        .o_a     (op_a),
        .o_b     (op_b)
    );

    assign in_ready = !w_full;
    assign busy     = (r_state != I_IDLE);
    assign stall    = (r_timer >= TMR_W'(REQ_TIMEOUT));
    assign spurious = r_spurious;

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        start       = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            I_IDLE: if (!w_empty && !locked && !done_flag) w_state_nxt = I_REQ;
            I_REQ: begin
                start = 1'b1;
                if (locked) w_state_nxt = I_RUN;
            end
            I_RUN: begin
                // locked dropping without done_flag is ignored
                if (done_flag) begin
                    w_pop       = 1'b1;
                    w_state_nxt = I_IDLE;
                end
            end
            default: w_state_nxt = I_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= I_IDLE;
        else      r_state <= w_state_nxt;
    end

    // REQ wait timer: counts unaccepted REQ cycles, saturates, clears outside REQ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (r_state == I_REQ && !locked) begin
            if (r_timer < TMR_W'(REQ_TIMEOUT)) r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    // Sticky flag for done_flag arriving with no job in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_spurious <= 1'b0;
        else if (done_flag && (r_state == I_IDLE || r_state == I_REQ)) r_spurious <= 1'b1;
    end

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue; the bench plays the multiplier control FSM.
module tb_mul_issue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       locked = 1'b0;
    logic       done_flag = 1'b0;
    logic [2:0] level;
    logic       busy;
    logic       stall;
    logic       spurious;

    int n_cmp = 0;
    int n_err = 0;

    mul_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .locked    (locked),
        .done_flag (done_flag),
        .level     (level),
        .busy      (busy),
        .stall     (stall),
        .spurious  (spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!start && n < 30) begin
            tick();
            n++;
        end
        chk("start_seen", start, 1);
    endtask

    // One full job; optionally pushes a new pair on the done_flag edge
    task automatic do_job(input logic [7:0] ea, input logic [7:0] eb, input logic [2:0] lvl_after,
                          input logic pu, input logic [7:0] pa, input logic [7:0] pb);
        wait_start();
        chk("req_op_a", op_a, ea);
        chk("req_op_b", op_b, eb);
        tick();
        chk("start_2nd_cycle", start, 1);
        locked = 1'b1;
        tick();
        chk("run_start_low", start, 0);
        chk("run_busy", busy, 1);
        chk("run_op_a", op_a, ea);
        tick();
        chk("run_op_b", op_b, eb);
        locked = 1'b0; done_flag = 1'b1;
        if (pu) begin in_valid = 1'b1; in_a = pa; in_b = pb; end
        #1;
        chk("done_op_a", op_a, ea);
        tick();
        done_flag = 1'b0; in_valid = 1'b0;
        chk("pop_level", level, lvl_after);
        chk("pop_busy", busy, 0);
    endtask

    initial begin
        #3 rst = 1'b0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_spurious", spurious, 0);
        tick();
        rst = 1'b1;
        tick();

        // single job
        push(8'h0F, 8'h11);
        chk("single_level", level, 1);
        chk("single_head_a", op_a, 8'h0F);
        do_job(8'h0F, 8'h11, 3'd0, 1'b0, 8'h00, 8'h00);
        chk("single_spurious", spurious, 0);

        // back-to-back jobs
        push(8'd3, 8'd5);
        push(8'd255, 8'd255);
        push(8'd0, 8'd7);
        chk("b2b_level", level, 3);
        do_job(8'd3, 8'd5, 3'd2, 1'b0, 8'h00, 8'h00);
        do_job(8'd255, 8'd255, 3'd1, 1'b0, 8'h00, 8'h00);
        do_job(8'd0, 8'd7, 3'd0, 1'b0, 8'h00, 8'h00);

        // full FIFO with control FSM held locked
        locked = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 8'h20 + 8'(i));
        chk("full_level", level, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_idle", busy, 0);
        push(8'hEE, 8'hEE);
        chk("full_reject_level", level, 4);
        locked = 1'b0;
        do_job(8'h10, 8'h20, 3'd3, 1'b0, 8'h00, 8'h00);
        chk("after_pop_in_ready", in_ready, 1);
        do_job(8'h11, 8'h21, 3'd2, 1'b0, 8'h00, 8'h00);
        do_job(8'h12, 8'h22, 3'd1, 1'b0, 8'h00, 8'h00);
        do_job(8'h13, 8'h23, 3'd0, 1'b0, 8'h00, 8'h00);

        // simultaneous push/pop at level 2
        push(8'hA1, 8'hB1);
        push(8'hA2, 8'hB2);
        do_job(8'hA1, 8'hB1, 3'd2, 1'b1, 8'hA3, 8'hB3);
        do_job(8'hA2, 8'hB2, 3'd1, 1'b0, 8'h00, 8'h00);
        do_job(8'hA3, 8'hB3, 3'd0, 1'b0, 8'h00, 8'h00);

        // stall: start never accepted for a while
        push(8'hA5, 8'h5A);
        wait_start();
        repeat (14) tick();
        chk("stall_14", stall, 0);
        tick();
        chk("stall_15", stall, 1);
        chk("stall_start", start, 1);
        tick();
        chk("stall_sat", stall, 1);
        locked = 1'b1;
        tick();
        chk("stall_cleared", stall, 0);
        chk("stall_run", busy, 1);
        chk("stall_run_start", start, 0);
        locked = 1'b0; done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        chk("stall_pop_level", level, 0);

        // spurious done_flag while idle
        locked = 1'b1;
        push(8'h01, 8'h02);
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        chk("spur_flag", spurious, 1);
        chk("spur_level", level, 1);
        chk("spur_idle", busy, 0);

        // reset mid-job
        push(8'h03, 8'h04);
        chk("rj_level", level, 2);
        locked = 1'b0;
        wait_start();
        locked = 1'b1;
        tick();
        chk("rj_run", busy, 1);
        rst = 1'b0;
        #1;
        chk("rj_level_rst", level, 0);
        chk("rj_in_ready", in_ready, 1);
        chk("rj_start", start, 0);
        chk("rj_busy", busy, 0);
        chk("rj_stall", stall, 0);
        chk("rj_spurious", spurious, 0);
        locked = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rj_stays_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_issue.md
Name: mul_issue

Overview:
- Upstream operand-issue stage for the 8-bit sequential multiplier.
- Buffers operand pairs from a valid/ready producer in a small FIFO and presents the head pair on op_a/op_b.
- Asserts start to the multiplier control FSM and holds the operands stable until the control FSM reports done_flag.
- Pops the completed entry, then issues the next one.

Parameters:
DATA_W, 8, operand width
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 2, log2(DEPTH)
REQ_TIMEOUT, 15, cycles in REQ without locked before stall asserts

Ports:
clk  in  1  clock
rst  in  1  async active-low reset
in_valid  in  1  producer has an operand pair
in_ready  out  1  FIFO can accept (not full)
in_a  in  DATA_W  multiplicand
in_b  in  DATA_W  multiplier
start  out  1  request to control FSM
op_a  out  DATA_W  head multiplicand, stable during a job
op_b  out  DATA_W  head multiplier, stable during a job
locked  in  1  control FSM busy (not IDLE/FINISH)
done_flag  in  1  control FSM in FINISH
level  out  ADDR_W+1  FIFO occupancy 0..DEPTH
busy  out  1  a job is requested or in flight
stall  out  1  REQ held > REQ_TIMEOUT cycles
spurious  out  1  sticky: done_flag seen with no job in flight

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. On reset, pointers, level, FSM, timer and spurious are cleared. in_ready=1, start=0, busy=0, stall=0, spurious=0. op_a/op_b are don't-care while level=0.
- FIFO write and read pointers are ADDR_W+1 bits; the MSB is a wrap bit.
  - full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
  - in_ready = !full, combinational.
  - A push occurs on an edge with in_valid && in_ready.
  - op_a/op_b are a combinational read of the entry at rd_ptr. Pushes never alter that entry.
  - A pushed pair is visible on op_a/op_b one cycle after the push edge if the FIFO was empty.
- Issue FSM states: I_IDLE, I_REQ, I_RUN.
  - I_IDLE: go to I_REQ when !empty && !locked && !done_flag.
  - I_REQ: start=1 (combinational from state). Go to I_RUN when locked=1. Otherwise stay and increment the timer.
  - I_RUN: start=0. When done_flag=1: pop the FIFO (rd_ptr+1, level-1) on that edge and go to I_IDLE.
  - busy = (state != I_IDLE).
- Nominal timing:
  - Edge 0: enter I_REQ.
  - Cycle 1: start=1; the control FSM leaves IDLE at the next edge.
  - locked is seen one cycle later. start remains high that cycle, which is harmless.
  - When done_flag is seen, the pop occurs. The next I_REQ follows at the earliest 1 cycle after returning to I_IDLE, once the control FSM is IDLE.
- stall: the timer counts cycles in I_REQ.
  - stall=1 while timer >= REQ_TIMEOUT.
  - The timer saturates and clears on leaving I_REQ.
  - Covers the case where the control FSM does not accept start because its step count is nonzero.
- spurious: set when done_flag=1 in I_IDLE or I_REQ. Cleared only by reset. done_flag in those states causes no pop.
- Simultaneous push and pop: both occur and level is unchanged. When full, in_ready=0, so a push is impossible even if a pop occurs in the same cycle (no bypass).
- level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- locked dropping in I_RUN without done_flag is ignored; stay in I_RUN.
- Reset mid-job: all state is discarded and buffered entries are lost. The control FSM is reset by the same rst.

Decomposition:
- Shared package mul_pkg holds:
  - issue state encoding (I_IDLE=2'b00, I_REQ=2'b01, I_RUN=2'b10);
  - DATA_W default;
  - the multiplier control state codes (IDLE..FINISH), for bench monitors.
- Sub-module mul_operand_fifo: parameterised DEPTH/DATA_W storage with pointers, full/empty/level, push/pop ports and the head read.
- The issue FSM, timer and flags stay in mul_issue.

Test Plan:
- Single job: push (a=8'h0F, b=8'h11). Expect start=1 for 2 cycles until locked; op_a/op_b held through done_flag; then level 1->0, busy=0.
- Back-to-back jobs: push (3,5), (255,255), (0,7) on consecutive cycles. Expect 3 start sequences in order, each operand pair stable for its full job, and level 3->2->1->0.
- Full FIFO: push 4 pairs with the control FSM held locked. Expect in_ready=0 at level=4; a 5th in_valid is not accepted; after done_flag, in_ready=1 and level=3.
- Simultaneous push/pop: at level=2, push on the done_flag edge. Expect level stays 2 and the new pair becomes the third job.
- Stall: the control FSM never asserts locked. Expect stall=1 after 15 REQ cycles with start still high; locked then arrives, stall=0 and the FSM enters I_RUN.
- Spurious/reset: pulse done_flag while idle, expect spurious=1 and level unchanged. Assert rst during I_RUN with level=2, expect all outputs at reset values immediately.
